// File: rtl/riscv_pkg.sv
// riscv_pkg: shared immediate-format codes, NOP word and instruction field positions
package riscv_pkg;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB = 7;
endpackage

// File: rtl/idu_pipe_if.sv
// idu_pipe_if: decode-stage bus; fetch/writeback/EX inputs and decode outputs
// master drives fetch/control/writeback inputs, slave (the decode stage) drives D-stage outputs
interface idu_pipe_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] PCF, PCplus4F;
  logic [31:0] InstrF;
  logic flushD;
  logic [2:0] ImmSrcD;
  logic RegWriteW;
  logic [4:0] RdW;
  logic [XLEN-1:0] ResultW;
  logic LoadE;
  logic [4:0] RdE;
  logic [31:0] InstrD;
  logic [XLEN-1:0] PCD, PCplus4D;
  logic ValidD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD;
  logic stallF, stallD, flushE;
  modport master (
    output PCF, PCplus4F, InstrF, flushD, ImmSrcD, RegWriteW, RdW, ResultW, LoadE, RdE,
    input InstrD, PCD, PCplus4D, ValidD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, stallF, stallD, flushE
  );
  modport slave (
    input PCF, PCplus4F, InstrF, flushD, ImmSrcD, RegWriteW, RdW, ResultW, LoadE, RdE,
    output InstrD, PCD, PCplus4D, ValidD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, stallF, stallD, flushE
  );
endinterface

// File: rtl/regfile_bp.sv
// regfile_bp: register file with x0 hardwired to zero and write-through bypass
// ports: clk, reset (sync active-low), we/wa/wd write port, ra1/ra2 -> rd1/rd2 combinational reads
module regfile_bp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam logic [5:0] NR = 6'(NREGS);
  logic [XLEN-1:0] rf [32];
  logic wen;
  // entries at or above NREGS exist only to keep indexing full-width; they are never written
  assign wen = we && wa != 5'd0 && {1'b0, wa} < NR;
  always_ff @(posedge clk) begin
    if (!reset) for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wen) rf[wa] <= wd;
  end
  assign rd1 = (ra1 == 5'd0 || {1'b0, ra1} >= NR) ? '0 : (wen && wa == ra1) ? wd : rf[ra1];
  assign rd2 = (ra2 == 5'd0 || {1'b0, ra2} >= NR) ? '0 : (wen && wa == ra2) ? wd : rf[ra2];
endmodule

// File: rtl/idu_pipe.sv
// idu_pipe: decode stage with IF/ID register, bypassed register file, immediate extender and load-use hazard unit
// ports: clk, reset (sync active-low), bus (idu_pipe_if.slave) carrying fetch/writeback/EX inputs and decode outputs
module idu_pipe import riscv_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input logic clk,
  input logic reset,
  idu_pipe_if.slave bus
);
  logic lwStall;
  logic [31:0] i, imm;
  assign i = bus.InstrD;
  assign bus.Rs1D = i[RS1_LSB +: 5];
  assign bus.Rs2D = i[RS2_LSB +: 5];
  assign bus.RdD = i[RD_LSB +: 5];
  // a load in EX whose result the valid decode instruction needs; gated so nothing stalls during reset
  assign lwStall = reset & bus.LoadE & bus.ValidD & (bus.RdE != 5'd0) & ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D));
  assign bus.stallF = lwStall;
  assign bus.stallD = lwStall;
  assign bus.flushE = lwStall;
  // flush outranks stall so a killed slot never lingers
  always_ff @(posedge clk) begin
    if (!reset || bus.flushD) begin
      bus.InstrD <= NOP;
      bus.PCD <= '0;
      bus.PCplus4D <= '0;
      bus.ValidD <= 1'b0;
    end else if (!lwStall) begin
      bus.InstrD <= bus.InstrF;
      bus.PCD <= bus.PCF;
      bus.PCplus4D <= bus.PCplus4F;
      bus.ValidD <= 1'b1;
    end
  end
  always_comb begin
    imm = bus.ImmSrcD == IMM_I ? {{20{i[31]}}, i[31:20]} :
          bus.ImmSrcD == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
          bus.ImmSrcD == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
          bus.ImmSrcD == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
          bus.ImmSrcD == IMM_U ? {i[31:12], 12'b0} : 32'b0;
  end
  assign bus.ImmExtD = XLEN'($signed(imm));
  regfile_bp #(.XLEN(XLEN), .NREGS(NREGS)) rf (
    .clk(clk),
    .reset(reset),
    .we(bus.RegWriteW),
    .wa(bus.RdW),
    .wd(bus.ResultW),
    .ra1(bus.Rs1D),
    .ra2(bus.Rs2D),
    .rd1(bus.RD1D),
    .rd2(bus.RD2D)
  );
endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Parametrised decode stage for the pipelined core.
- Sits between the fetch stage and the execute-stage pipeline register.
- Contains the IF/ID pipeline register with valid tracking, and a register file with write-through bypass from writeback.
- Also contains a 5-format immediate extender and a load-use hazard detector that drives the fetch/decode stall and execute flush.
- Generalises the previous decode unit to XLEN=32/64 and NREGS=16 (RV32E) or 32; adds U-type immediates, same-cycle W→D forwarding and built-in hazard control.

Parameters:
- XLEN, 32, datapath/register width; legal values 32 or 64.
- NREGS, 32, architectural register count; legal values 16 or 32.
- NOP, 32'h0000_0013, instruction word injected on reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock; only clock of the block.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- PCF  in  XLEN  fetch PC.
- PCplus4F  in  XLEN  fetch PC+4.
- InstrF  in  32  fetched instruction.
- flushD  in  1  kill the decode slot (taken branch/jump).
- ImmSrcD  in  3  immediate format from the control unit: 000 I, 001 S, 010 B, 011 J, 100 U.
- RegWriteW  in  1  writeback write enable.
- RdW  in  5  writeback destination.
- ResultW  in  XLEN  writeback data.
- LoadE  in  1  instruction in EX is a load (ResultSrcE==mem).
- RdE  in  5  EX destination register.
- InstrD  out  32  decode-stage instruction.
- PCD  out  XLEN  decode-stage PC.
- PCplus4D  out  XLEN  decode-stage PC+4.
- ValidD  out  1  decode slot holds a real instruction.
- Rs1D, Rs2D, RdD  out  5 each  InstrD[19:15], InstrD[24:20], InstrD[11:7].
- RD1D, RD2D  out  XLEN  register operands, bypassed.
- ImmExtD  out  XLEN  sign-extended immediate.
- stallF, stallD  out  1 each  hold PC / hold IF/ID.
- flushE  out  1  insert bubble into ID/EX.

Behaviour:
- Reset (reset==0 at a clk edge):
  - InstrD←NOP, PCD←0, PCplus4D←0, ValidD←0.
  - All registers x1..x(NREGS-1)←0.
  - Reset overrides all other inputs, including mid-stall.
- IF/ID register update, in priority order on each edge:
  - reset.
  - flushD=1: InstrD←NOP, PCD←0, PCplus4D←0, ValidD←0.
  - stallD=1: hold all values.
  - Otherwise: load InstrF/PCF/PCplus4F and set ValidD←1.
- Flush priority:
  - flushD beats stallD when both are asserted in the same cycle.
  - The flushed slot yields ValidD=0 next cycle, with no stall.
- Register file:
  - x0 reads 0 and is never written.
  - Write on the clk edge when RegWriteW=1, RdW≠0 and RdW<NREGS.
  - Indices ≥NREGS read 0 and are ignored on write; with NREGS=16, bit 4 set → out of range.
- Read ports are combinational, with bypass:
  - If RegWriteW=1, RdW==ra, ra≠0 and ra<NREGS, then RDxD=ResultW (same-cycle write-then-read).
  - Otherwise RDxD = stored value.
- Immediate extension (sign bit is InstrD[31]; the result is sign-extended to XLEN):
  - I: {InstrD[31:20]}.
  - S: {InstrD[31:25],InstrD[11:7]}.
  - B: {InstrD[31],InstrD[7],InstrD[30:25],InstrD[11:8],1'b0}.
  - J: {InstrD[31],InstrD[19:12],InstrD[20],InstrD[30:21],1'b0}.
  - U: {InstrD[31:12],12'b0}.
  - Undefined ImmSrcD → 0.
- Hazard detection (combinational, zero latency):
  - lwStall = LoadE & ValidD & (RdE≠0) & (RdE==Rs1D | RdE==Rs2D).
  - stallF = stallD = flushE = lwStall.
  - Outputs are forced to 0 while reset==0.
- Latency:
  - Fetch inputs appear on the D outputs one cycle later.
  - Register writes are visible in the same cycle through the bypass.
- A stall lasts exactly one cycle per load-use pair: the bubble enters EX, so LoadE deasserts the next cycle.

Decomposition:
- Shared package riscv_pkg:
  - IMM_I/IMM_S/IMM_B/IMM_J/IMM_U 3-bit constants.
  - NOP_INSTR.
  - Field-slice localparams (RS1_LSB=15, RS2_LSB=20, RD_LSB=7).
- One sub-module: regfile_bp, parametrised by XLEN/NREGS, holding storage and bypass.
- The pipeline register, extender and hazard logic stay inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with InstrF=32'hFFFF_FFFF → InstrD=32'h0000_0013, ValidD=0, PCD=0, RD1D=0 for any Rs1D.
- Bypass: RegWriteW=1, RdW=5, ResultW=32'hDEAD_BEEF while InstrD has rs1=5 → RD1D=32'hDEAD_BEEF in the same cycle; the write is stored and still read next cycle with RegWriteW=0; the same with RdW=0 → RD1D=0.
- Load-use: InstrD=add x3,x1,x2 (ValidD=1), LoadE=1, RdE=2 → stallF=stallD=flushE=1; InstrD/PCD held for 1 cycle; with RdE=0 → no stall.
- Flush vs stall: flushD=1 and stallD=1 in the same cycle → next cycle InstrD=NOP, ValidD=0, stall deasserted.
- Immediates: InstrD=32'hFFF0_0093 with I → ImmExtD=-1; 32'h8000_006F with J → ImmExtD=-1048576 (XLEN=32) or 64'hFFFF_FFFF_FFF0_0000 (XLEN=64); 32'h1234_5037 with U → 32'h1234_5000.
- RV32E (NREGS=16): write RdW=17 with 32'h55 → no write occurs; reading rs1=17 returns 0, and reading x1 is unchanged.
